// File: rtl/dot_mac_engine.sv
// Dot-product MAC engine: loads a data/weight vector pair, accumulates sum(data[k]*weight[k]),
// then drains the accumulator in OUT_W-bit chunks. Define DOT_MAC_SATURATE_EN to clamp on overflow.
//
// state   | meaning
// S_LOAD  | accept data/weight beats until both banks hold LANES elements
// S_COMPUTE | one multiply-accumulate per cycle, LANES cycles
// S_DRAIN | present accumulator chunks, least-significant first
module dot_mac_engine #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_mode,
  input  logic             w_hold,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             ovf
);

  localparam int NCHUNK = (ACC_W + OUT_W - 1) / OUT_W;
  localparam int CW     = $clog2(LANES + 1);
  localparam int IW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int HW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PW     = 2 * DW;
  localparam logic [CW-1:0] FULL       = CW'(LANES);
  localparam logic [IW-1:0] LAST_IDX   = IW'(LANES - 1);
  localparam logic [HW-1:0] LAST_CHUNK = HW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DW-1:0]           r_data [LANES];
  logic [DW-1:0]           r_wgt  [LANES];
  logic [CW-1:0]           r_cnt_d, r_cnt_w;
  logic [CW-1:0]           w_cnt_d_nxt, w_cnt_w_nxt;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           w_wr_idx;
  logic [HW-1:0]           r_chunk;
  logic [ACC_W-1:0]        r_acc;
  logic [ACC_W-1:0]        w_acc_nxt;
  logic                    r_ovf;
  logic                    w_beat, w_enter, w_out_hs, w_final_hs, w_carry;
  logic [PW-1:0]           w_prod;
  logic [ACC_W:0]          w_sum;
  logic [NCHUNK*OUT_W-1:0] w_acc_pad;

  assign in_ready    = (r_state == S_LOAD) && (in_sel ? (r_cnt_w < FULL) : (r_cnt_d < FULL));
  assign w_beat      = in_valid & in_ready;
  assign w_wr_idx    = in_sel ? r_cnt_w[IW-1:0] : r_cnt_d[IW-1:0];
  assign w_cnt_d_nxt = r_cnt_d + CW'(w_beat & ~in_sel);
  assign w_cnt_w_nxt = r_cnt_w + CW'(w_beat & in_sel);
  assign w_out_hs    = out_valid & out_ready;
  assign w_final_hs  = w_out_hs & out_last;
  assign w_enter     = (r_state == S_LOAD) && (w_state_nxt == S_COMPUTE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Entering COMPUTE on the edge that accepts the last beat gives out_valid at t+LANES+1.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if ((w_cnt_d_nxt == FULL) && (w_cnt_w_nxt == FULL)) w_state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (r_idx == LAST_IDX) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_final_hs) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  assign out_valid = (r_state == S_DRAIN);
  assign out_last  = out_valid && (r_chunk == LAST_CHUNK);

  always_comb begin
    w_acc_pad              = '0;
    w_acc_pad[ACC_W-1:0]   = r_acc;
  end

  assign out_data = out_valid ? w_acc_pad[r_chunk*OUT_W +: OUT_W] : '0;

  assign w_prod  = {{DW{1'b0}}, r_data[r_idx]} * {{DW{1'b0}}, r_wgt[r_idx]};
  assign w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - PW){1'b0}}, w_prod};
  assign w_carry = w_sum[ACC_W];

`ifdef DOT_MAC_SATURATE_EN
  assign w_acc_nxt = w_carry ? '1 : w_sum[ACC_W-1:0];
`else
  assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_enter && !acc_mode) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == S_COMPUTE) begin
      r_acc <= w_acc_nxt;
      if (w_carry) r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;

  // Weight count survives the drain only when w_hold asks to reuse the weights.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_d <= '0;
      r_cnt_w <= '0;
      r_idx   <= '0;
      r_chunk <= '0;
    end else begin
      if (w_final_hs) begin
        r_cnt_d <= '0;
        r_cnt_w <= w_hold ? FULL : '0;
      end else begin
        r_cnt_d <= w_cnt_d_nxt;
        r_cnt_w <= w_cnt_w_nxt;
      end
      if (r_state == S_COMPUTE) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      if (w_out_hs) begin
        r_chunk <= (r_chunk == LAST_CHUNK) ? '0 : r_chunk + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) begin
      if (in_sel) begin
        r_wgt[w_wr_idx] <= in_data;
      end else begin
        r_data[w_wr_idx] <= in_data;
      end
    end
  end

endmodule

// File: doc/dot_mac_engine.md
DOT_MAC_ENGINE -- requirements
Module: dot_mac_engine

Interface
REQ-001 SHALL have parameter LANES, default 4: vector length.
REQ-002 SHALL have parameter DW, default 8: unsigned element width.
REQ-003 SHALL have parameter ACC_W, default 24: accumulator width; legal only if ACC_W >= 2*DW + clog2(LANES).
REQ-004 SHALL have parameter OUT_W, default 8: output chunk width; NCHUNK = ceil(ACC_W/OUT_W).
REQ-005 SHALL have port clk  in  1  clock.
REQ-006 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-007 SHALL have port in_data  in  DW  element being loaded.
REQ-008 SHALL have port in_sel  in  1  bank select: 0=data, 1=weight.
REQ-009 SHALL have port in_valid  in  1  load beat offered.
REQ-010 SHALL have port in_ready  out  1  load beat accepted when in_valid&in_ready.
REQ-011 SHALL have port acc_mode  in  1  1=add to prior result, 0=start from zero; sampled on COMPUTE entry.
REQ-012 SHALL have port w_hold  in  1  keep weights for next vector; sampled on final chunk handshake.
REQ-013 SHALL have port out_data  out  OUT_W  result chunk.
REQ-014 SHALL have port out_valid  out  1  chunk valid.
REQ-015 SHALL have port out_ready  in  1  chunk consumed when out_valid&out_ready.
REQ-016 SHALL have port out_last  out  1  marks final chunk.
REQ-017 SHALL have port ovf  out  1  sticky overflow flag.

Function
REQ-018 SHALL implement FSM states LOAD, COMPUTE, DRAIN.
REQ-019 In LOAD, each accepted beat SHALL write in_data to index cnt[in_sel] of the selected bank and increment that count; index 0 is loaded first.
REQ-020 in_ready SHALL be 1 only in LOAD while cnt[in_sel] < LANES; a beat offered to a full bank SHALL stall without affecting the other bank.
REQ-021 The FSM SHALL enter COMPUTE on the cycle after both counts reach LANES.
REQ-022 On COMPUTE entry the accumulator SHALL be cleared if acc_mode=0 and kept if acc_mode=1.
REQ-023 COMPUTE SHALL last exactly LANES cycles; cycle k SHALL add data[k]*weight[k] to the accumulator, modulo 2^ACC_W.
REQ-024 Latency: if the last load beat is accepted in cycle t, out_valid SHALL first be 1 in cycle t+LANES+1.
REQ-025 DRAIN SHALL emit NCHUNK chunks, least-significant first; unused upper bits of the top chunk SHALL be 0.
REQ-026 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 out_last SHALL be 1 only with the final chunk.
REQ-028 After the final chunk handshake the FSM SHALL return to LOAD with data count 0.
REQ-029 On that same handshake the weight count SHALL become LANES if w_hold=1 and 0 otherwise; the accumulator SHALL be retained.
REQ-030 ovf SHALL set when any COMPUTE addition exceeds 2^ACC_W-1, and SHALL clear only on reset or on COMPUTE entry with acc_mode=0.

Reset
REQ-031 When rst_n=0 at a clock edge, the FSM SHALL go to LOAD, clear both counts, the accumulator, ovf, out_valid, out_last and out_data, and drive in_ready=1 on the following cycle.
REQ-032 Reset SHALL take effect in any state, including mid-COMPUTE and mid-DRAIN; no partial chunk SHALL be emitted afterwards.

Configuration
REQ-033 Macro DOT_MAC_SATURATE_EN, when defined, SHALL clamp the accumulator to 2^ACC_W-1 on overflow, and ovf SHALL still set.
REQ-034 When DOT_MAC_SATURATE_EN is undefined, the accumulator SHALL wrap modulo 2^ACC_W, and ovf SHALL still set.

Verification (LANES=4, DW=8, ACC_W=24, OUT_W=8)
REQ-035 Scenario: data 1,2,3,4 and weights 5,6,7,8 with acc_mode=0 -> chunks 0x46, 0x00, 0x00; out_last on the third; out_valid exactly 5 cycles after the last beat.
REQ-036 Scenario: all elements 0xFF -> chunks 0x04, 0xF8, 0x03 (260100); ovf=0.
REQ-037 Scenario: REQ-035 result, then w_hold=1, then reload data only with acc_mode=1 -> 0x8C, 0x00, 0x00; no weight beats accepted.
REQ-038 Scenario: out_ready low for 5 cycles on the first chunk -> 0x46 held stable, then the sequence completes normally.
REQ-039 Scenario: 65 all-0xFF vectors with acc_mode=1 after the first -> ovf=1; result 129284 (0x04, 0xF9, 0x01) without the macro, 0xFF, 0xFF, 0xFF with it.
REQ-040 Scenario: reset asserted during the second DRAIN chunk -> out_valid=0 next cycle, then a fresh REQ-035 load yields 0x46.
